// File: rtl/accel_spi_sequencer_if.sv
// Byte handshake and chip select between the accelerometer sequencer (master)
// and the byte-level SPI shifter (slave).
interface accel_spi_sequencer_if;
  logic       byte_start;
  logic [7:0] byte_tx;
  logic       byte_done;
  logic [7:0] byte_rx;
  logic       cs_n;

  modport master (
    output byte_start,
    output byte_tx,
    output cs_n,
    input  byte_done,
    input  byte_rx
  );

  modport slave (
    input  byte_start,
    input  byte_tx,
    input  cs_n,
    output byte_done,
    output byte_rx
  );
endinterface

// File: rtl/accel_spi_sequencer.sv
// Accelerometer transaction sequencer: POWER_CTL setup, then periodic XDATA..ZDATA burst reads.
// Build macro ACCEL_DEVID_CHECK_EN prepends a device-ID read that must return 8'hAD.
module accel_spi_sequencer #(
  parameter int unsigned SAMPLE_DIV    = 1000000,
  parameter int unsigned CS_GAP        = 10,
  parameter logic [7:0]  POWER_CTL_VAL = 8'h02
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable_i,
  accel_spi_sequencer_if.master        spi,
  output logic [7:0]                   x_data_o,
  output logic [7:0]                   y_data_o,
  output logic [7:0]                   z_data_o,
  output logic                         sample_valid_o,
  output logic                         busy_o,
  output logic                         error_o
);

  localparam int TICK_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int GAP_W  = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_DIV - 1);
  localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(CS_GAP - 1);
  localparam logic [GAP_W-1:0]  GAP_ONE   = GAP_W'(1);

  localparam logic [7:0] CMD_WRITE      = 8'h0A;
  localparam logic [7:0] CMD_READ       = 8'h0B;
  localparam logic [7:0] ADDR_POWER_CTL = 8'h2D;
  localparam logic [7:0] ADDR_XDATA     = 8'h08;
  localparam logic [7:0] DUMMY_BYTE     = 8'h00;

  typedef enum logic [4:0] {
    IDLE, CFG_CS, CFG_CMD, CFG_ADDR, CFG_DATA, GAP, WAIT_TICK,
    RD_CS, RD_CMD, RD_ADDR, RD_X, RD_Y, RD_Z, RD_END
`ifdef ACCEL_DEVID_CHECK_EN
    , ID_CS, ID_CMD, ID_ADDR, ID_DUMMY, ERR
`endif
  } state_e;

`ifdef ACCEL_DEVID_CHECK_EN
  localparam logic [7:0] ADDR_DEVID = 8'h00;
  localparam logic [7:0] DEVID_EXP  = 8'hAD;
  localparam state_e     START_STATE = ID_CS;
`else
  localparam state_e     START_STATE = CFG_CS;
`endif

  function automatic logic is_byte_state(input state_e s);
    logic r;
    case (s)
      CFG_CMD, CFG_ADDR, CFG_DATA, RD_CMD, RD_ADDR, RD_X, RD_Y, RD_Z: r = 1'b1;
`ifdef ACCEL_DEVID_CHECK_EN
      ID_CMD, ID_ADDR, ID_DUMMY: r = 1'b1;
`endif
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_cs_low(input state_e s);
    logic r;
    case (s)
      CFG_CS, CFG_CMD, CFG_ADDR, CFG_DATA,
      RD_CS, RD_CMD, RD_ADDR, RD_X, RD_Y, RD_Z: r = 1'b1;
`ifdef ACCEL_DEVID_CHECK_EN
      ID_CS, ID_CMD, ID_ADDR, ID_DUMMY: r = 1'b1;
`endif
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] tx_byte(input state_e s);
    logic [7:0] b;
    case (s)
      CFG_CMD:  b = CMD_WRITE;
      CFG_ADDR: b = ADDR_POWER_CTL;
      CFG_DATA: b = POWER_CTL_VAL;
      RD_CMD:   b = CMD_READ;
      RD_ADDR:  b = ADDR_XDATA;
`ifdef ACCEL_DEVID_CHECK_EN
      ID_CMD:   b = CMD_READ;
      ID_ADDR:  b = ADDR_DEVID;
`endif
      default:  b = DUMMY_BYTE;
    endcase
    return b;
  endfunction

  state_e            state_q, state_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic              tick_wrap_s;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              pending_q, pending_d;
  logic              done_s;
  logic              cs_n_q, cs_n_d;
  logic              start_q, start_d;
  logic [7:0]        tx_q, tx_d;
  logic [7:0]        x_sh_q, x_sh_d, y_sh_q, y_sh_d, z_sh_q, z_sh_d;
  logic [7:0]        x_q, x_d, y_q, y_d, z_q, z_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
`ifdef ACCEL_DEVID_CHECK_EN
  logic              error_q, error_d;
  logic              cfg_pend_q, cfg_pend_d;
`endif

  // A done pulse only counts while a byte is outstanding and not in its own start cycle.
  assign done_s = spi.byte_done & pending_q & ~start_q;

  // Free-running sample tick counter.
  always_comb begin
    tick_wrap_s = (tick_q == TICK_LAST);
    if (tick_wrap_s) begin
      tick_d = '0;
    end else begin
      tick_d = tick_q + TICK_ONE;
    end
  end

  // Next-state logic plus the registered-output next values derived from it.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    x_sh_d  = x_sh_q;
    y_sh_d  = y_sh_q;
    z_sh_d  = z_sh_q;
`ifdef ACCEL_DEVID_CHECK_EN
    error_d    = error_q;
    cfg_pend_d = cfg_pend_q;
`endif

    case (state_q)
      IDLE:      state_d = enable_i ? START_STATE : IDLE;
      CFG_CS:    state_d = CFG_CMD;
      CFG_CMD:   state_d = done_s ? CFG_ADDR : CFG_CMD;
      CFG_ADDR:  state_d = done_s ? CFG_DATA : CFG_ADDR;
      CFG_DATA:  state_d = done_s ? GAP : CFG_DATA;
      GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d = '0;
`ifdef ACCEL_DEVID_CHECK_EN
          state_d    = cfg_pend_q ? CFG_CS : WAIT_TICK;
          cfg_pend_d = 1'b0;
`else
          state_d = WAIT_TICK;
`endif
        end else begin
          gap_d = gap_q + GAP_ONE;
        end
      end
      WAIT_TICK: state_d = (tick_wrap_s && enable_i) ? RD_CS : WAIT_TICK;
      RD_CS:     state_d = RD_CMD;
      RD_CMD:    state_d = done_s ? RD_ADDR : RD_CMD;
      RD_ADDR:   state_d = done_s ? RD_X : RD_ADDR;
      RD_X: begin
        if (done_s) begin
          state_d = RD_Y;
          x_sh_d  = spi.byte_rx;
        end else begin
          state_d = RD_X;
        end
      end
      RD_Y: begin
        if (done_s) begin
          state_d = RD_Z;
          y_sh_d  = spi.byte_rx;
        end else begin
          state_d = RD_Y;
        end
      end
      RD_Z: begin
        if (done_s) begin
          state_d = RD_END;
          z_sh_d  = spi.byte_rx;
        end else begin
          state_d = RD_Z;
        end
      end
      RD_END:    state_d = GAP;
`ifdef ACCEL_DEVID_CHECK_EN
      ID_CS:     state_d = ID_CMD;
      ID_CMD:    state_d = done_s ? ID_ADDR : ID_CMD;
      ID_ADDR:   state_d = done_s ? ID_DUMMY : ID_ADDR;
      ID_DUMMY: begin
        if (!done_s) begin
          state_d = ID_DUMMY;
        end else if (spi.byte_rx == DEVID_EXP) begin
          state_d    = GAP;
          cfg_pend_d = 1'b1;
        end else begin
          state_d = ERR;
          error_d = 1'b1;
        end
      end
      ERR:       state_d = ERR;
`endif
      default:   state_d = IDLE;
    endcase

    // Outputs are registered against state_d so they line up with state_q.
    cs_n_d    = ~is_cs_low(state_d);
    start_d   = is_byte_state(state_d) && (state_d != state_q);
    tx_d      = start_d ? tx_byte(state_d) : tx_q;
    pending_d = start_d ? 1'b1 : (done_s ? 1'b0 : pending_q);
    busy_d    = ~cs_n_d | pending_d;
    valid_d   = (state_d == RD_END);
    x_d       = valid_d ? x_sh_d : x_q;
    y_d       = valid_d ? y_sh_d : y_q;
    z_d       = valid_d ? z_sh_d : z_q;
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      tick_q    <= '0;
      gap_q     <= '0;
      pending_q <= 1'b0;
      cs_n_q    <= 1'b1;
      start_q   <= 1'b0;
      tx_q      <= 8'h00;
      x_sh_q    <= 8'h00;
      y_sh_q    <= 8'h00;
      z_sh_q    <= 8'h00;
      x_q       <= 8'h00;
      y_q       <= 8'h00;
      z_q       <= 8'h00;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
`ifdef ACCEL_DEVID_CHECK_EN
      error_q    <= 1'b0;
      cfg_pend_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      gap_q     <= gap_d;
      pending_q <= pending_d;
      cs_n_q    <= cs_n_d;
      start_q   <= start_d;
      tx_q      <= tx_d;
      x_sh_q    <= x_sh_d;
      y_sh_q    <= y_sh_d;
      z_sh_q    <= z_sh_d;
      x_q       <= x_d;
      y_q       <= y_d;
      z_q       <= z_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
`ifdef ACCEL_DEVID_CHECK_EN
      error_q    <= error_d;
      cfg_pend_q <= cfg_pend_d;
`endif
    end
  end

  assign spi.byte_start  = start_q;
  assign spi.byte_tx     = tx_q;
  assign spi.cs_n        = cs_n_q;
  assign x_data_o        = x_q;
  assign y_data_o        = y_q;
  assign z_data_o        = z_q;
  assign sample_valid_o  = valid_q;
  assign busy_o          = busy_q;
`ifdef ACCEL_DEVID_CHECK_EN
  assign error_o         = error_q;
`else
  assign error_o         = 1'b0;
`endif

endmodule

// File: tb/tb_accel_spi_sequencer.sv
// Directed bench for accel_spi_sequencer: SPI byte responder with variable latency,
// a protocol monitor on the falling edge, and hand-computed expected bytes and samples.
module tb_accel_spi_sequencer;

  localparam int unsigned SAMPLE_DIV = 100;
  localparam int unsigned CS_GAP     = 10;
`ifdef ACCEL_DEVID_CHECK_EN
  localparam int ID_N = 3;
`else
  localparam int ID_N = 0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] x_data, y_data, z_data;
  logic       sample_valid, busy, error;

  accel_spi_sequencer_if spi ();

  accel_spi_sequencer #(
    .SAMPLE_DIV(SAMPLE_DIV),
    .CS_GAP(CS_GAP),
    .POWER_CTL_VAL(8'h02)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable_i(enable),
    .spi(spi),
    .x_data_o(x_data),
    .y_data_o(y_data),
    .z_data_o(z_data),
    .sample_valid_o(sample_valid),
    .busy_o(busy),
    .error_o(error)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // stimulus knobs (written by the main sequence only)
  int         dly;
  logic [7:0] resp [3];
  logic [7:0] dev_id;
  int         spur_req = 0;

  // responder state
  int         spur_ack = 0;
  int         idx = 0;
  logic [7:0] b0 = 8'h00, b1 = 8'h00, rsp = 8'h00;

  // monitor state
  logic [7:0] tx_log [$];
  int   cyc = 0, cs_fall_cyc = 0, cs_rise_cyc = 0, last_done_cyc = 0;
  int   start_after_cs = -1, rise_after_done = -1, min_gap = 1000000;
  int   cs_fall_cnt = 0, sample_cnt = 0, valid_run = 0, max_run = 0, viol = 0;
  logic cs_prev = 1'b1, outstanding = 1'b0, first_in_txn = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // SPI slave: answers each byte_start after dly cycles; idx counts bytes within one cs_n low window.
  initial begin
    spi.byte_done = 1'b0;
    spi.byte_rx   = 8'h00;
    forever begin
      @(posedge clk); #1;
      spi.byte_done = 1'b0;
      if (spi.cs_n) idx = 0;
      if (spi.byte_start) begin
        if (idx == 0) b0 = spi.byte_tx;
        if (idx == 1) b1 = spi.byte_tx;
        if (b0 == 8'h0B && b1 == 8'h08 && idx >= 2 && idx <= 4) rsp = resp[idx-2];
        else if (b0 == 8'h0B && b1 == 8'h00 && idx == 2) rsp = dev_id;
        else rsp = 8'h00;
        idx++;
        repeat (dly) @(posedge clk);
        #1;
        spi.byte_done = 1'b1;
        spi.byte_rx   = rsp;
      end else if (spur_req != spur_ack) begin
        spi.byte_done = 1'b1;
        spi.byte_rx   = 8'hFF;
        spur_ack++;
      end
    end
  end

  // Monitor: logs transmitted bytes and measures cs_n / handshake timing.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (cs_prev && !spi.cs_n) begin
        if (cs_fall_cnt > 0 && (cyc - cs_rise_cyc) < min_gap) min_gap = cyc - cs_rise_cyc;
        cs_fall_cyc  = cyc;
        cs_fall_cnt++;
        first_in_txn = 1'b1;
      end
      if (!cs_prev && spi.cs_n) begin
        cs_rise_cyc     = cyc;
        rise_after_done = cyc - last_done_cyc;
      end
      cs_prev = spi.cs_n;
      if (reset) begin
        outstanding = 1'b0;
      end else begin
        if (spi.byte_start) begin
          if (outstanding) viol++;
          outstanding = 1'b1;
          tx_log.push_back(spi.byte_tx);
          if (first_in_txn) begin
            start_after_cs = cyc - cs_fall_cyc;
            first_in_txn   = 1'b0;
          end
        end else if (spi.byte_done && outstanding) begin
          outstanding   = 1'b0;
          last_done_cyc = cyc;
        end
      end
      if (sample_valid) begin
        sample_cnt++;
        valid_run++;
        if (valid_run > max_run) max_run = valid_run;
      end else begin
        valid_run = 0;
      end
    end
  end

  task automatic wait_log(input int n, input int budget);
    int k = 0;
    while (tx_log.size() < n && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    chk("wait_bytes", (tx_log.size() >= n), 1);
  endtask

  task automatic wait_samples(input int n, input int budget);
    int k = 0;
    while (sample_cnt < n && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    chk("wait_sample", (sample_cnt >= n), 1);
  endtask

  task automatic check_cfg(input int base);
`ifdef ACCEL_DEVID_CHECK_EN
    chk("id_cmd",   tx_log[base],   8'h0B);
    chk("id_addr",  tx_log[base+1], 8'h00);
    chk("id_dummy", tx_log[base+2], 8'h00);
`endif
    chk("cfg_cmd",  tx_log[base+ID_N],   8'h0A);
    chk("cfg_addr", tx_log[base+ID_N+1], 8'h2D);
    chk("cfg_data", tx_log[base+ID_N+2], 8'h02);
  endtask

  task automatic check_burst(input int base, input logic [7:0] ex, input logic [7:0] ey,
                             input logic [7:0] ez);
    chk("rd_cmd",  tx_log[base],   8'h0B);
    chk("rd_addr", tx_log[base+1], 8'h08);
    for (int i = 2; i < 5; i++) chk("rd_dummy", tx_log[base+i], 8'h00);
    chk("x_data", x_data, ex);
    chk("y_data", y_data, ey);
    chk("z_data", z_data, ez);
    chk("cs_rise_after_done", rise_after_done, 1);
  endtask

  initial begin
    int base;
    int ls;
    int fc;
    int k;
    reset  = 1'b1;
    enable = 1'b0;
    dly    = 1;
    dev_id = 8'hAD;
    resp[0] = 8'h12; resp[1] = 8'h34; resp[2] = 8'h56;

    repeat (3) @(posedge clk); #1;
    chk("rst_cs_n",       spi.cs_n,       1);
    chk("rst_byte_start", spi.byte_start, 0);
    chk("rst_byte_tx",    spi.byte_tx,    8'h00);
    chk("rst_x",          x_data,         8'h00);
    chk("rst_y",          y_data,         8'h00);
    chk("rst_z",          z_data,         8'h00);
    chk("rst_valid",      sample_valid,   0);
    chk("rst_busy",       busy,           0);
    chk("rst_error",      error,          0);

    // configuration after reset release
    enable = 1'b1;
    reset  = 1'b0;
    wait_log(ID_N + 3, 400);
    check_cfg(0);
    chk("cs_setup", start_after_cs, 1);

    // burst 1, one-cycle byte latency
    wait_samples(1, 1000);
    check_burst(ID_N + 3, 8'h12, 8'h34, 8'h56);
    repeat (14) @(posedge clk); #1;
    chk("valid_width", max_run, 1);
    chk("valid_count", sample_cnt, 1);

    // spurious byte_done while waiting for the tick
    base = tx_log.size();
    spur_req = 1;
    repeat (3) @(posedge clk); #1;
    chk("spur_busy",     busy, 0);
    chk("spur_cs_n",     spi.cs_n, 1);
    chk("spur_no_start", tx_log.size(), base);

    // burst 2, seven-cycle latency
    resp[0] = 8'hA1; resp[1] = 8'hB2; resp[2] = 8'hC3;
    dly = 7;
    wait_samples(2, 1500);
    check_burst(base, 8'hA1, 8'hB2, 8'hC3);

    // burst 3, forty-cycle latency (ticks in between are dropped)
    base = tx_log.size();
    resp[0] = 8'h0F; resp[1] = 8'hF0; resp[2] = 8'h5A;
    dly = 40;
    wait_samples(3, 2000);
    check_burst(base, 8'h0F, 8'hF0, 8'h5A);
    chk("valid_count3", sample_cnt, 3);

    // enable dropped while the Y byte is in flight
    base = tx_log.size();
    resp[0] = 8'h11; resp[1] = 8'h22; resp[2] = 8'h33;
    dly = 7;
    wait_log(base + 4, 1000);
    enable = 1'b0;
    wait_samples(4, 1000);
    check_burst(base, 8'h11, 8'h22, 8'h33);
    fc = cs_fall_cnt;
    ls = tx_log.size();
    repeat (350) @(posedge clk); #1;
    chk("dis_no_cs_fall", cs_fall_cnt, fc);
    chk("dis_no_bytes",   tx_log.size(), ls);
    chk("dis_cs_n",       spi.cs_n, 1);
    resp[0] = 8'h44; resp[1] = 8'h55; resp[2] = 8'h66;
    enable = 1'b1;
    wait_samples(5, 1000);
    check_burst(ls, 8'h44, 8'h55, 8'h66);

    // reset asserted mid-cycle during RD_X
    dly  = 1;
    base = tx_log.size();
    wait_log(base + 2, 1000);
    k = 0;
    while (!spi.byte_start && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("rdx_start_seen", spi.byte_start, 1);
    chk("rdx_cs_low",     spi.cs_n, 0);
    #2;
    reset = 1'b1;
    #1;
    chk("async_cs_n",       spi.cs_n, 1);
    chk("async_byte_start", spi.byte_start, 0);
    chk("async_busy",       busy, 0);
    repeat (12) @(posedge clk); #1;
    ls = tx_log.size();
    resp[0] = 8'h77; resp[1] = 8'h88; resp[2] = 8'h99;
    reset = 1'b0;
    wait_log(ls + ID_N + 3, 400);
    check_cfg(ls);
    wait_samples(6, 1000);
    check_burst(ls + ID_N + 3, 8'h77, 8'h88, 8'h99);

    chk("no_double_start", viol, 0);
    chk("cs_gap_min", (min_gap >= CS_GAP), 1);

`ifdef ACCEL_DEVID_CHECK_EN
    // wrong device ID parks the block with error set
    reset  = 1'b1;
    dev_id = 8'hE5;
    repeat (3) @(posedge clk); #1;
    chk("rst_error_clr", error, 0);
    ls = tx_log.size();
    fc = cs_fall_cnt;
    reset = 1'b0;
    wait_log(ls + 3, 300);
    repeat (400) @(posedge clk); #1;
    chk("devid_error",   error, 1);
    chk("devid_cs_n",    spi.cs_n, 1);
    chk("devid_busy",    busy, 0);
    chk("devid_bytes",   tx_log.size(), ls + 3);
    chk("devid_one_txn", cs_fall_cnt, fc + 1);
`else
    chk("error_tied", error, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
